// File: rtl/header_stream.sv
// Block header generator: accumulates per-channel min/max over BLOCK_PIX pixels
// and presents min, max, residual width, constant flag and compressable flag.
// Optional feature macro: HEADER_STREAM_SKIP_EN (drives out_skip from min==max).
module header_stream #(
   parameter int NUM_CH    = 4,
   parameter int CH_W      = 8,
   parameter int BLOCK_PIX = 32,
   parameter int LANES     = 8
) (
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  in_valid,
   output logic                                  in_ready,
   input  logic [LANES*NUM_CH*CH_W-1:0]          in_pixels,
   output logic                                  out_valid,
   input  logic                                  out_ready,
   output logic [NUM_CH*CH_W-1:0]                out_min,
   output logic [NUM_CH*CH_W-1:0]                out_max,
   output logic [NUM_CH*$clog2(CH_W+1)-1:0]      out_bits,
   output logic [NUM_CH-1:0]                     out_skip,
   output logic                                  out_compressable
);

   localparam int BEATS  = BLOCK_PIX / LANES;
   localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam int BITS_W = $clog2(CH_W + 1);

   // Handshake: a beat transfers on a cycle where in_valid && in_ready; a result
   // transfers on a cycle where out_valid && out_ready. Neither ready depends on
   // the matching valid, and both output sides come straight from state.
   typedef enum logic {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q;
   logic [CH_W-1:0]   acc_min  [NUM_CH];
   logic [CH_W-1:0]   acc_max  [NUM_CH];
   logic [CH_W-1:0]   beat_min [NUM_CH];
   logic [CH_W-1:0]   beat_max [NUM_CH];
   logic              accept;
   logic              last_beat;

   function automatic logic [BITS_W-1:0] width_of(input logic [CH_W-1:0] d);
      width_of = '0;
      for (int i = 0; i < CH_W; i++) begin
         if (d[i]) width_of = BITS_W'(i + 1);
      end
   endfunction

   // Per-channel reduction across the lanes of the current beat.
   always_comb begin
      for (int c = 0; c < NUM_CH; c++) begin
         beat_min[c] = in_pixels[c*CH_W +: CH_W];
         beat_max[c] = in_pixels[c*CH_W +: CH_W];
         for (int l = 1; l < LANES; l++) begin
            if (in_pixels[(l*NUM_CH+c)*CH_W +: CH_W] < beat_min[c])
               beat_min[c] = in_pixels[(l*NUM_CH+c)*CH_W +: CH_W];
            if (in_pixels[(l*NUM_CH+c)*CH_W +: CH_W] > beat_max[c])
               beat_max[c] = in_pixels[(l*NUM_CH+c)*CH_W +: CH_W];
         end
      end
   end

   assign accept    = in_valid && in_ready;
   assign last_beat = (cnt_q == CNT_W'(BEATS - 1));

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ACCUM: begin
            in_ready = 1'b1;
            if (in_valid && last_beat) state_d = HOLD;
         end
         HOLD: begin
            out_valid = 1'b1;
            if (out_ready) state_d = ACCUM;
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         for (int c = 0; c < NUM_CH; c++) begin
            acc_min[c] <= '0;
            acc_max[c] <= '0;
         end
      end else begin
         state_q <= state_d;
         if (accept) begin
            cnt_q <= last_beat ? '0 : cnt_q + CNT_W'(1);
            // The first beat of a block overwrites, so nothing carries over.
            for (int c = 0; c < NUM_CH; c++) begin
               if (cnt_q == '0) begin
                  acc_min[c] <= beat_min[c];
                  acc_max[c] <= beat_max[c];
               end else begin
                  acc_min[c] <= (beat_min[c] < acc_min[c]) ? beat_min[c] : acc_min[c];
                  acc_max[c] <= (beat_max[c] > acc_max[c]) ? beat_max[c] : acc_max[c];
               end
            end
         end
      end
   end

   // Header fields derive only from registered accumulators and state.
   always_comb begin
      out_min          = '0;
      out_max          = '0;
      out_bits         = '0;
      out_skip         = '0;
      out_compressable = 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
         out_min[c*CH_W +: CH_W]     = acc_min[c];
         out_max[c*CH_W +: CH_W]     = acc_max[c];
         out_bits[c*BITS_W +: BITS_W] = width_of(acc_max[c] - acc_min[c]);
         if ((state_q == HOLD) && (width_of(acc_max[c] - acc_min[c]) < BITS_W'(CH_W)))
            out_compressable = 1'b1;
`ifdef HEADER_STREAM_SKIP_EN
         out_skip[c] = (state_q == HOLD) && (acc_min[c] == acc_max[c]);
`endif
      end
   end

endmodule
